// File: rtl/screenmem_write_arbiter_pkg.sv
// Shared screen-memory constants, tile/code typedefs and writer FSM states.
// Ports: none (package scrmem_pkg).
package scrmem_pkg;

    localparam int SCR_COLS  = 40;
    localparam int SCR_ROWS  = 30;
    localparam int SCR_NLOC  = 1200;
    localparam int SCR_ABITS = $clog2(SCR_NLOC);
    localparam int SCR_DBITS = 4;

    typedef logic [SCR_ABITS-1:0] tile_addr_t;
    typedef logic [SCR_DBITS-1:0] chcode_t;

    typedef enum logic {
        FILL,
        SERVE
    } scrwr_state_e;

    // Unsigned range test for a tile address of any width up to 32 bits.
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input int unsigned nloc);
        return addr < nloc;
    endfunction

endpackage

// File: rtl/screenmem_write_arbiter_if.sv
// Requester/fill handshake plus registered screen-memory write bus.
// master: requesters and fill command; slave: the write arbiter.
interface screenmem_write_arbiter_if
    import scrmem_pkg::*;
#(
    parameter int Abits = SCR_ABITS,
    parameter int Dbits = SCR_DBITS
);

    logic             fill_req;
    logic [Dbits-1:0] fill_code;
    logic             fill_busy;

    logic             r0_valid;
    logic [Abits-1:0] r0_addr;
    logic [Dbits-1:0] r0_data;
    logic             r0_ready;

    logic             r1_valid;
    logic [Abits-1:0] r1_addr;
    logic [Dbits-1:0] r1_data;
    logic             r1_ready;

    logic             we;
    logic [Abits-1:0] waddr;
    logic [Dbits-1:0] wdata;
    logic             drop;

    modport master (
        output fill_req, fill_code,
        output r0_valid, r0_addr, r0_data,
        output r1_valid, r1_addr, r1_data,
        input  fill_busy, r0_ready, r1_ready,
        input  we, waddr, wdata, drop
    );

    modport slave (
        input  fill_req, fill_code,
        input  r0_valid, r0_addr, r0_data,
        input  r1_valid, r1_addr, r1_data,
        output fill_busy, r0_ready, r1_ready,
        output we, waddr, wdata, drop
    );

endinterface

// File: rtl/screenmem_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; prio flips to the other side after a grant.
// Ports: clk, reset_n, req[1:0], enable in; gnt[1:0] out (one-hot or 0).
module rr_arb2
    import scrmem_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    // 0 favours requester 0 on a tie, 1 favours requester 1.
    logic prio_q;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            unique case (req)
                2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
                default: gnt = req;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= 1'b0;
        end else if (gnt[0]) begin
            prio_q <= 1'b1;
        end else if (gnt[1]) begin
            prio_q <= 1'b0;
        end
    end

endmodule

// File: rtl/screenmem_write_arbiter.sv
// Screen-memory write port owner: full-screen fill engine plus 2-way RR arbiter.
// Ports: clk, reset_n, [vblank when SCRWR_VBLANK_GATE_EN], bus (slave modport).
module screenmem_write_arbiter
    import scrmem_pkg::*;
#(
    parameter int               Nloc       = SCR_NLOC,
    parameter int               Abits      = $clog2(Nloc),
    parameter int               Dbits      = SCR_DBITS,
    parameter logic [Dbits-1:0] RESET_CODE = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
`ifdef SCRWR_VBLANK_GATE_EN
    input  logic                      vblank,
`endif
    screenmem_write_arbiter_if.slave  bus
);

    localparam logic [Abits-1:0] LAST = Abits'(Nloc - 1);

    scrwr_state_e     state_q, state_d;
    logic [Abits-1:0] cnt_q, cnt_d;
    logic [Dbits-1:0] code_q, code_d;

    logic             we_q, we_d;
    logic [Abits-1:0] waddr_q, waddr_d;
    logic [Dbits-1:0] wdata_q, wdata_d;
    logic             drop_q, drop_d;

    logic             go;
    logic             arb_en;
    logic [1:0]       gnt;

`ifdef SCRWR_VBLANK_GATE_EN
    assign go = vblank;
`else
    assign go = 1'b1;
`endif

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({bus.r1_valid, bus.r0_valid}),
        .enable  (arb_en),
        .gnt     (gnt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        drop_d  = 1'b0;
        arb_en  = 1'b0;

        unique case (state_q)
            FILL: begin
                // fill_req is deliberately not looked at here.
                if (go) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q;
                    wdata_d = code_q;
                    if (cnt_q == LAST) begin
                        state_d = SERVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SERVE: begin
                if (bus.fill_req) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    code_d  = bus.fill_code;
                end else begin
                    arb_en = go;
                    unique case (1'b1)
                        gnt[0]: begin
                            if (addr_ok(32'(bus.r0_addr), Nloc)) begin
                                we_d    = 1'b1;
                                waddr_d = bus.r0_addr;
                                wdata_d = bus.r0_data;
                            end else begin
                                drop_d = 1'b1;
                            end
                        end
                        gnt[1]: begin
                            if (addr_ok(32'(bus.r1_addr), Nloc)) begin
                                we_d    = 1'b1;
                                waddr_d = bus.r1_addr;
                                wdata_d = bus.r1_data;
                            end else begin
                                drop_d = 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            code_q  <= RESET_CODE;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.r0_ready  = gnt[0];
    assign bus.r1_ready  = gnt[1];
    assign bus.fill_busy = (state_q == FILL);
    assign bus.we        = we_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.drop      = drop_q;

endmodule

// File: tb/tb_screenmem_write_arbiter.sv
// Randomized + directed bench for screenmem_write_arbiter with a behavioural model.
// Ports: none (top-level testbench).
module tb_screenmem_write_arbiter;
    import scrmem_pkg::*;

    localparam int N = 1200;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    screenmem_write_arbiter_if bus ();

    screenmem_write_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef SCRWR_VBLANK_GATE_EN
        .vblank  (1'b1),
`endif
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Behavioural model: fill progress, tie-break owner, expected outputs.
    bit         m_fill;
    int         m_cnt;
    chcode_t    m_code;
    bit         m_prio;
    logic [1:0] m_g;
    logic       e_we, e_drop;
    tile_addr_t e_waddr;
    chcode_t    e_wdata;
    tile_addr_t m_a;
    chcode_t    m_d;

    function automatic logic [1:0] model_ready();
        if (m_fill || bus.fill_req) return 2'b00;
        if (bus.r0_valid && bus.r1_valid) return m_prio ? 2'b10 : 2'b01;
        return {bus.r1_valid, bus.r0_valid};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_fill = 1; m_cnt = 0; m_code = '0; m_prio = 0;
            e_we = 0; e_drop = 0; e_waddr = '0; e_wdata = '0;
        end else begin
            m_g = model_ready();
            e_we = 0;
            e_drop = 0;
            if (m_fill) begin
                e_we = 1;
                e_waddr = m_cnt[10:0];
                e_wdata = m_code;
                m_cnt++;
                if (m_cnt == N) m_fill = 0;
            end else if (bus.fill_req) begin
                m_fill = 1;
                m_cnt = 0;
                m_code = bus.fill_code;
            end else if (m_g != 2'b00) begin
                m_a = m_g[0] ? bus.r0_addr : bus.r1_addr;
                m_d = m_g[0] ? bus.r0_data : bus.r1_data;
                m_prio = m_g[0];
                if (32'(m_a) < N) begin
                    e_we = 1; e_waddr = m_a; e_wdata = m_d;
                end else begin
                    e_drop = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        #3;
        chk("cmp_we", 32'(bus.we), 32'(e_we));
        chk("cmp_waddr", 32'(bus.waddr), 32'(e_waddr));
        chk("cmp_wdata", 32'(bus.wdata), 32'(e_wdata));
        chk("cmp_drop", 32'(bus.drop), 32'(e_drop));
        chk("cmp_busy", 32'(bus.fill_busy), 32'(m_fill));
        chk("cmp_ready", 32'({bus.r1_ready, bus.r0_ready}), 32'(model_ready()));
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic run_fill(input chcode_t code, input string name,
                            input bit poke);
        int idx = 0;
        int bound = 0;
        cyc();
        while (bus.fill_busy && bound < 1300) begin
            if (bus.we && 32'(bus.waddr) == idx && bus.wdata == code) idx++;
            bus.fill_req = poke && bound == 500;
            bus.fill_code = 4'h3;
            cyc();
            bound++;
        end
        bus.fill_req = 1'b0;
        if (bus.we && 32'(bus.waddr) == idx && bus.wdata == code) idx++;
        chk({name, "_timeout"}, 32'(bound < 1300), 32'd1);
        chk({name, "_count"}, 32'(idx), 32'd1200);
        chk({name, "_last"}, 32'(bus.waddr), 32'd1199);
    endtask

    initial begin
        int bound;
        int ea[4] = '{5, 7, 5, 7};
        int ed[4] = '{3, 9, 3, 9};
        bus.fill_req = 0; bus.fill_code = '0;
        bus.r0_valid = 0; bus.r0_addr = '0; bus.r0_data = '0;
        bus.r1_valid = 0; bus.r1_addr = '0; bus.r1_data = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_we", 32'(bus.we), 0);
        chk("rst_waddr", 32'(bus.waddr), 0);
        chk("rst_wdata", 32'(bus.wdata), 0);
        chk("rst_drop", 32'(bus.drop), 0);
        chk("rst_busy", 32'(bus.fill_busy), 1);
        reset_n = 1'b1;
        run_fill(4'h0, "post_reset_fill", 0);

        // Both requesters continuously valid: alternate from r0.
        bus.r0_valid = 1; bus.r0_addr = 11'd5; bus.r0_data = 4'd3;
        bus.r1_valid = 1; bus.r1_addr = 11'd7; bus.r1_data = 4'd9;
        #1;
        chk("alt_first_r0", 32'({bus.r1_ready, bus.r0_ready}), 32'b01);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("alt_we", 32'(bus.we), 1);
            chk("alt_waddr", 32'(bus.waddr), 32'(ea[i]));
            chk("alt_wdata", 32'(bus.wdata), 32'(ed[i]));
        end
        bus.r0_valid = 0; bus.r1_valid = 0;

        // r1 alone for three cycles.
        for (int i = 0; i < 3; i++) begin
            bus.r1_valid = 1;
            bus.r1_addr = 11'(100 + i);
            bus.r1_data = 4'(i + 1);
            #1;
            chk("r1_alone_rdy", 32'({bus.r1_ready, bus.r0_ready}), 32'b10);
            cyc();
            chk("r1_alone_we", 32'(bus.we), 1);
            chk("r1_alone_waddr", 32'(bus.waddr), 32'(100 + i));
            chk("r1_alone_wdata", 32'(bus.wdata), 32'(i + 1));
        end
        bus.r1_valid = 0;
        cyc();
        chk("idle_we", 32'(bus.we), 0);

        // Out-of-range r0 request wins the tie, then is dropped.
        bus.r0_valid = 1; bus.r0_addr = 11'd1200; bus.r0_data = 4'd2;
        bus.r1_valid = 1; bus.r1_addr = 11'd50; bus.r1_data = 4'd7;
        #1;
        chk("oor_rdy", 32'({bus.r1_ready, bus.r0_ready}), 32'b01);
        cyc();
        chk("oor_we", 32'(bus.we), 0);
        chk("oor_drop", 32'(bus.drop), 1);
        bus.r0_addr = 11'd10; bus.r0_data = 4'd1;
        bus.r1_addr = 11'd20; bus.r1_data = 4'd4;
        #1;
        chk("after_drop_rdy", 32'({bus.r1_ready, bus.r0_ready}), 32'b10);
        cyc();
        chk("after_drop_waddr", 32'(bus.waddr), 20);
        chk("after_drop_wdata", 32'(bus.wdata), 4);
        chk("after_drop_drop", 32'(bus.drop), 0);
        bus.r0_valid = 0; bus.r1_valid = 0;

        // Commanded fill beats a pending r0 request.
        bus.r0_valid = 1; bus.r0_addr = 11'd30; bus.r0_data = 4'd5;
        bus.fill_req = 1; bus.fill_code = 4'hF;
        #1;
        chk("fill_blocks_r0", 32'(bus.r0_ready), 0);
        cyc();
        bus.fill_req = 0;
        chk("fill_start_we", 32'(bus.we), 0);
        chk("fill_start_busy", 32'(bus.fill_busy), 1);
        run_fill(4'hF, "cmd_fill", 1);
        #1;
        chk("post_fill_r0_rdy", 32'(bus.r0_ready), 1);
        cyc();
        chk("post_fill_r0_waddr", 32'(bus.waddr), 30);
        chk("post_fill_r0_wdata", 32'(bus.wdata), 5);
        bus.r0_valid = 0;

        // Reset asserted in the middle of a fill.
        bus.fill_req = 1; bus.fill_code = 4'h6;
        cyc();
        bus.fill_req = 0;
        bound = 0;
        while (!(bus.we && bus.waddr == 11'd600) && bound < 1300) begin
            cyc();
            bound++;
        end
        chk("mid_reach_600", 32'(bound < 1300), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(bus.we), 0);
        chk("mid_rst_busy", 32'(bus.fill_busy), 1);
        cyc();
        cyc();
        reset_n = 1'b1;
        run_fill(4'h0, "refill", 0);

        // Randomized traffic with occasional fill commands.
        repeat (4000) begin
            bus.r0_valid = 1'($urandom_range(0, 1));
            bus.r0_addr = ($urandom_range(0, 4) == 0) ?
                11'($urandom_range(1200, 2047)) : 11'($urandom_range(0, 1199));
            bus.r0_data = 4'($urandom);
            bus.r1_valid = 1'($urandom_range(0, 1));
            bus.r1_addr = ($urandom_range(0, 4) == 0) ?
                11'($urandom_range(1200, 2047)) : 11'($urandom_range(0, 1199));
            bus.r1_data = 4'($urandom);
            bus.fill_req = ($urandom_range(0, 599) == 0);
            bus.fill_code = 4'($urandom);
            cyc();
        end
        bus.r0_valid = 0; bus.r1_valid = 0; bus.fill_req = 0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/screenmem_write_arbiter.md
# screenmem_write_arbiter

Write-side controller for the tile screen memory read by the VGA display driver. It shares the single screen-memory write port between two requesters (maze generator, player/cursor logic) with round-robin arbitration. It also contains a fill engine that sweeps every tile address with one character code, both after reset and on command. It emits one registered write per cycle at most.

## Interface

- Nloc, 1200: number of tiles (40 columns × 30 rows).
- Abits, $clog2(Nloc): tile address width.
- Dbits, 4: character-code width, matching chcode.
- RESET_CODE, 0: code written by the automatic post-reset fill.

- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fill_req  in  1  start a fill with fill_code; single-cycle pulse or level.
- fill_code  in  Dbits  fill value, sampled on the accepted fill_req edge.
- fill_busy  out  1  high while the fill engine owns the port.
- r0_valid, r1_valid  in  1  write request.
- r0_addr, r1_addr  in  Abits  tile address.
- r0_data, r1_data  in  Dbits  character code.
- r0_ready, r1_ready  out  1  grant; a transfer occurs on valid && ready.
- we  out  1  screen-memory write enable (registered).
- waddr  out  Abits  write address (registered).
- wdata  out  Dbits  write data (registered).
- drop  out  1  one-cycle pulse: the accepted request had addr ≥ Nloc.

## Operation

- States: FILL, SERVE. Reset forces FILL with cnt=0 and code=RESET_CODE.
- FILL:
  - Each cycle registers we=1, waddr=cnt, wdata=code, then increments cnt.
  - The cycle that issues cnt=Nloc-1 transitions to SERVE.
  - Exactly Nloc writes, ascending from 0, no gaps.
  - r0_ready and r1_ready are 0 in FILL.
  - fill_req in FILL is ignored; there is no restart and no queueing.
- SERVE:
  - fill_req=1 transitions to FILL with cnt=0 and code=fill_code. That cycle grants nothing, and fill has priority over pending requests.
  - Otherwise the arbiter grants at most one requester per cycle.
- Arbitration:
  - Readies are combinational from the valids, the state and the pointer prio.
  - If only one requester is valid, it gets ready.
  - If both are valid, the one selected by prio gets ready.
  - After any grant, prio points to the other requester.
  - prio resets to r0.
  - A ready is never asserted without its valid.
- Accepted request with addr < Nloc: next cycle we=1, waddr=addr, wdata=data.
- Accepted request with addr ≥ Nloc: next cycle we=0 and drop=1. It still counts as a grant for prio.
- Idle cycles register we=0. waddr and wdata hold their previous values.
- Reset values: we=0, waddr=0, wdata=0, drop=0, fill_busy=1, prio=r0.
- Arithmetic: cnt is Abits wide and is compared against Nloc-1 only, never wrapped by overflow. The address compare is unsigned.

## Timing

- Latency is one cycle from the valid && ready edge to we, waddr and wdata.
- Throughput is one write per cycle, with back-to-back grants allowed.
- Post-reset fill:
  - The first write (addr 0) is visible after the first rising clk following reset_n release.
  - The last write (addr Nloc-1) is visible Nloc cycles after release.
- fill_busy equals (state==FILL). It drops in the same cycle the final fill write is on the outputs.
- A commanded fill writes addr 0 in the cycle after the fill_req edge. The port is busy for Nloc cycles.
- Asserting reset_n low mid-fill or mid-transfer:
  - we drops immediately (asynchronous) and any in-flight write is lost.
  - The fill restarts from 0 with RESET_CODE after release.
- Simultaneous fill_req and both valids in SERVE: no ready is asserted, and the fill starts.

## Configuration

- SCRWR_VBLANK_GATE_EN:
  - Defined: adds input vblank (1 bit). Grants and fill writes occur only in cycles where vblank=1. Outside vblank, readies are 0, cnt holds and we=0, and the fill pauses and resumes without skipping addresses.
  - Undefined: the vblank port is absent, and writes proceed in every cycle as above.

## Structure

- Shared package scrmem_pkg:
  - Constants SCR_COLS=40, SCR_ROWS=30, SCR_NLOC=1200.
  - Typedefs tile_addr_t (Abits) and chcode_t (Dbits).
  - State enum scrwr_state_e {FILL, SERVE}.
- One sub-module, rr_arb2: a 2-way round-robin arbiter holding prio. Its inputs are req[1:0] and enable; its outputs are gnt[1:0].
- Fill counter, FSM and output registers live in the top module.

## Test plan

- Reset release, no requests → exactly 1200 writes, addr 0..1199 in order, all wdata=0. fill_busy falls when addr 1199 is output.
- Both requesters continuously valid in SERVE (r0: addr 5/data 3, r1: addr 7/data 9) → writes alternate 5,7,5,7, starting with r0.
- r1 alone valid for 3 cycles → r1_ready=1 each cycle; three writes with 1-cycle latency. prio then favours r0.
- r0 requests addr 1200 → r0_ready=1; next cycle we=0 and drop=1. The next r1 request wins over r0.
- fill_req with fill_code=0xF while r0 is valid → r0_ready=0 and 1200 writes of 0xF. r0 is served the cycle after fill_busy falls. A second fill_req mid-fill has no effect.
- reset_n pulsed low at fill addr 600 → we=0 immediately; fill restarts at addr 0 after release.
